fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Read-side drainer for the dual-clock fifo_hdl block; lives in the read clock domain.
//  Pops words through the FIFO read port (rd_en/rd_data/empty/almost_empty/rd_count).
//  Emits them as valid/ready bursts of BURST_LEN words with m_last on the final word.
//  A timeout flushes a partial burst when the FIFO holds fewer than BURST_LEN words.
// PARAMETERS
//  DSIZE      8   data width; must match the FIFO DSIZE
//  BURST_LEN  4   words per full burst, 1..16
//  TIMEOUT    16  idle cycles with data present before a partial burst is flushed, >=2
//  ALMOST     3   must equal the FIFO ALMOST setting, >=2
// PORTS
//  rd_clk        in   1      FIFO read clock; sole clock of this block
//  rd_rst        in   1      synchronous active-high reset
//  rd_en         out  1      FIFO pop request
//  rd_data       in   DSIZE  FIFO read data; holds the popped word the cycle after rd_en
//  rd_count      in   5      FIFO read-side fill count (registered, lags 1 cycle)
//  empty         in   1      FIFO empty flag (registered, lags 1 cycle)
//  almost_empty  in   1      FIFO almost-empty flag
//  m_valid       out  1      output word valid
//  m_ready       in   1      downstream accept
//  m_data        out  DSIZE  output word
//  m_last        out  1      final word of the current burst
//  busy          out  1      high in every state except IDLE
//  burst_cnt     out  16     completed bursts, wraps at 2^16
// BEHAVIOUR
//  Reset (sync, rd_rst=1 at rd_clk edge):
//   - Outputs rd_en, m_valid, m_last, busy = 0; m_data = 0; burst_cnt = 0.
//   - FSM goes to IDLE; skid buffer, in-flight flag, timeout and settle counters clear.
//   - Reset mid-burst discards every buffered and in-flight word.
//  FSM states:
//   - IDLE: settle counter blocks any decision for 2 cycles after entry.
//     - rd_count>=BURST_LEN: latch len=BURST_LEN, go READ.
//     - Otherwise, while empty=0, the timeout counter increments each cycle.
//     - At TIMEOUT-1 with rd_count>0: latch len=rd_count, go READ.
//     - The timeout counter clears on empty=1 and on leaving IDLE.
//   - READ: issues len pops, then goes to DRAIN.
//   - DRAIN: waits until the skid buffer is empty and no read is in flight.
//     It then increments burst_cnt and returns to IDLE.
//  Read issue rules. rd_en=1 in cycle t only if all of these hold:
//   - state is READ and remaining>0;
//   - empty=0;
//   - buffered + in-flight words < 2;
//   - (almost_empty=0 or rd_en was 0 in t-1); this is the pacing guard against stale flags.
//  Data path:
//   - The word popped at t is captured from rd_data at t+1 into a 2-entry skid buffer.
//   - m_data/m_valid come from the buffer head; transfer = m_valid & m_ready.
//   - Throughput is 1 word/cycle while almost_empty=0 and m_ready=1.
//   - m_data and m_valid stay stable while m_valid=1 and m_ready=0.
//   - m_last=1 exactly on the len-th transferred word of a burst.
//   - After that word, m_valid=0 until the next burst.
//  Width rules:
//   - len and remaining are 5 bits.
//   - burst_cnt wraps 0xFFFF -> 0x0000.
//  Boundaries:
//   - len=1: a single word carries m_last=1.
//   - FIFO wrap-around is transparent to this block.
//   - Writes arriving during a burst do not extend len.
// TESTING
//  - 8 words pre-loaded, m_ready=1, BURST_LEN=4: two bursts; m_last on words 4 and 8; burst_cnt=2; data order preserved.
//  - 3 words loaded, no further writes: after TIMEOUT idle cycles, one burst of 3; m_last on word 3; FIFO ends empty.
//  - Burst in progress, m_ready low for 5 cycles: m_data/m_valid held; rd_en stops after 2 outstanding words; no loss or duplication.
//  - 1 word loaded, TIMEOUT=2: single-word burst with m_last=1; no extra rd_en while empty.
//  - rd_rst asserted mid-burst: next cycle m_valid=0, rd_en=0, busy=0, burst_cnt=0; a new 4-word load yields a clean burst.
//  - 20 random-gap writes, random m_ready: output stream equals input stream; m_last every 4th word.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
// Read-port and stream signals between fifo_burst_reader, the FIFO read side and the sink.
// master: the burst reader; slave: the FIFO/sink environment.
interface fifo_burst_reader_if #(
   parameter int unsigned DSIZE = 8
);
   logic             rd_en;
   logic [DSIZE-1:0] rd_data;
   logic [4:0]       rd_count;
   logic             empty;
   logic             almost_empty;
   logic             m_valid;
   logic             m_ready;
   logic [DSIZE-1:0] m_data;
   logic             m_last;

   modport master (
      output rd_en,
      output m_valid,
      output m_data,
      output m_last,
      input  rd_data,
      input  rd_count,
      input  empty,
      input  almost_empty,
      input  m_ready
   );

   modport slave (
      input  rd_en,
      input  m_valid,
      input  m_data,
      input  m_last,
      output rd_data,
      output rd_count,
      output empty,
      output almost_empty,
      output m_ready
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a dual-clock FIFO read port into valid/ready bursts of BURST_LEN words,
// flushing a partial burst after TIMEOUT idle cycles with data present.
module fifo_burst_reader #(
   parameter int unsigned DSIZE     = 8,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned TIMEOUT   = 16,
   parameter int unsigned ALMOST    = 3
) (
   input  logic                i_rd_clk,
   input  logic                i_rd_rst,
   fifo_burst_reader_if.master io_bus,
   output logic                o_busy,
   output logic [15:0]         o_burst_cnt
);

   if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_chk_len
      $error("fifo_burst_reader: BURST_LEN must be in 1..16");
   end
   if (TIMEOUT < 2) begin : g_chk_tmo
      $error("fifo_burst_reader: TIMEOUT must be >= 2");
   end
   if (ALMOST < 2) begin : g_chk_almost
      $error("fifo_burst_reader: ALMOST must be >= 2");
   end

   localparam int unsigned     TmoW      = $clog2(TIMEOUT);
   localparam logic [TmoW-1:0] TmoMax    = TmoW'(TIMEOUT - 1);
   localparam logic [4:0]      BurstLen5 = 5'(BURST_LEN);

   typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

   state_e            r_state;
   state_e            w_state_nxt;
   logic [1:0]        r_settle;
   logic [TmoW-1:0]   r_tmo;
   logic [4:0]        r_len;
   logic [4:0]        r_remain;
   logic [4:0]        r_xfer;
   logic [DSIZE-1:0]  r_buf [2];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_cnt;
   logic              r_inflight;
   logic [15:0]       r_burst_cnt;

   logic              w_settled;
   logic              w_full;
   logic              w_tmo_hit;
   logic              w_start;
   logic [4:0]        w_len_nxt;
   logic              w_valid;
   logic              w_xfer;
   logic [2:0]        w_occ;
   logic              w_rd_en;
   logic              w_drain_done;

   // Decision inputs: rd_count lags, so IDLE waits out the settle window first.
   always_comb begin
      w_settled    = (r_settle == 2'd2);
      w_full       = (io_bus.rd_count >= BurstLen5);
      w_tmo_hit    = (r_tmo == TmoMax) && (io_bus.rd_count != 5'd0);
      w_start      = (r_state == StIdle) && w_settled && (w_full || w_tmo_hit);
      w_len_nxt    = w_full ? BurstLen5 : io_bus.rd_count;
      w_valid      = (r_cnt != 2'd0);
      w_xfer       = w_valid && io_bus.m_ready;
      w_drain_done = (r_cnt == 2'd0) && !r_inflight;
   end

   // Occupancy counts the word leaving this cycle so a free-flowing sink gets 1 word/cycle.
   always_comb begin
      w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_xfer};
      w_rd_en = (r_state == StRead) && (r_remain != 5'd0) && !io_bus.empty &&
                (w_occ < 3'd2) && (!io_bus.almost_empty || !r_inflight) && !i_rd_rst;
   end

   always_ff @(posedge i_rd_clk) begin
      if (i_rd_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_start) begin
               w_state_nxt = StRead;
            end
         end
         StRead: begin
            if (r_remain == 5'd0) begin
               w_state_nxt = StDrain;
            end
         end
         StDrain: begin
            if (w_drain_done) begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      io_bus.rd_en   = w_rd_en;
      io_bus.m_valid = w_valid;
      io_bus.m_data  = r_buf[r_rptr];
      io_bus.m_last  = w_valid && ((r_xfer + 5'd1) == r_len);
      o_busy         = (r_state != StIdle);
      o_burst_cnt    = r_burst_cnt;
   end

   // IDLE bookkeeping: settle window and idle-with-data timeout.
   always_ff @(posedge i_rd_clk) begin
      if (i_rd_rst) begin
         r_settle <= 2'd0;
         r_tmo    <= '0;
      end else begin
         if (r_state != StIdle) begin
            r_settle <= 2'd0;
         end else if (!w_settled) begin
            r_settle <= r_settle + 2'd1;
         end

         if ((r_state != StIdle) || w_start || io_bus.empty) begin
            r_tmo <= '0;
         end else if (r_tmo != TmoMax) begin
            r_tmo <= r_tmo + TmoW'(1);
         end
      end
   end

   // Burst length, pops left to issue and words already handed downstream.
   always_ff @(posedge i_rd_clk) begin
      if (i_rd_rst) begin
         r_len       <= 5'd0;
         r_remain    <= 5'd0;
         r_xfer      <= 5'd0;
         r_burst_cnt <= 16'd0;
      end else begin
         if (w_start) begin
            r_len    <= w_len_nxt;
            r_remain <= w_len_nxt;
            r_xfer   <= 5'd0;
         end else begin
            if (w_rd_en) begin
               r_remain <= r_remain - 5'd1;
            end
            if (w_xfer) begin
               r_xfer <= r_xfer + 5'd1;
            end
         end

         if ((r_state == StDrain) && w_drain_done) begin
            r_burst_cnt <= r_burst_cnt + 16'd1;
         end
      end
   end

   // Two-entry skid buffer; the popped word appears on rd_data one cycle after rd_en.
   always_ff @(posedge i_rd_clk) begin
      if (i_rd_rst) begin
         r_buf[0]   <= '0;
         r_buf[1]   <= '0;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_cnt      <= 2'd0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         if (r_inflight) begin
            r_buf[r_wptr] <= io_bus.rd_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_xfer) begin
            r_rptr <= ~r_rptr;
         end
         r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_xfer};
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a lagging-flag FIFO model feeds the DUT and a
// scoreboard checks data order, m_last placement, handshake hold and burst counts.
module tb_fifo_burst_reader;
   localparam int unsigned DSIZE = 8;
   localparam int unsigned BL    = 4;
   localparam int unsigned TMO   = 16;
   localparam int unsigned ALM   = 3;

   typedef struct {
      int n_words;
      int rmod;
      int exp_bursts;
      bit exp_flush;
   } row_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy;
   logic [15:0] bcnt;

   fifo_burst_reader_if #(.DSIZE(DSIZE)) bus ();

   fifo_burst_reader #(
      .DSIZE    (DSIZE),
      .BURST_LEN(BL),
      .TIMEOUT  (TMO),
      .ALMOST   (ALM)
   ) dut (
      .i_rd_clk   (clk),
      .i_rd_rst   (rst),
      .io_bus     (bus),
      .o_busy     (busy),
      .o_burst_cnt(bcnt)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] fq[$];
   logic [7:0] sb[$];
   logic [7:0] wr_val = 8'h10;
   int         cyc_no = 0;
   int         k_burst = 0;
   int         n_xfer = 0;
   int         first_valid = -1;
   bit         partial_ok = 1'b1;
   bit         prev_stall = 1'b0;
   bit         prev_last = 1'b0;
   bit         prev_rst = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       rd_en_s;
   int         exp_bcnt = 0;
   row_t       rows[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_no);
      end
   endtask

   task automatic load(input int n);
      for (int i = 0; i < n; i++) begin
         fq.push_back(wr_val);
         sb.push_back(wr_val);
         wr_val = wr_val + 8'd1;
      end
   endtask

   // One clock: sample/check at negedge, then update the FIFO model after the edge.
   task automatic cyc();
      int  s_prev;
      bit  exp_last;
      @(negedge clk);
      rd_en_s = bus.rd_en;
      if (prev_stall && !prev_rst) begin
         check("hold_valid", 32'(bus.m_valid), 32'd1);
         check("hold_data", 32'(bus.m_data), 32'(prev_data));
      end
      if (prev_last && !prev_rst) check("valid_after_last", 32'(bus.m_valid), 32'd0);
      if (bus.m_valid && first_valid < 0) first_valid = cyc_no;
      prev_stall = bus.m_valid && !bus.m_ready && !rst;
      prev_data  = bus.m_data;
      prev_last  = 1'b0;
      prev_rst   = rst;
      if (bus.m_valid && bus.m_ready && !rst) begin
         if (sb.size() == 0) begin
            check("spurious_word", 32'd1, 32'd0);
         end else begin
            exp_last = ((k_burst + 1) == int'(BL)) || (partial_ok && sb.size() == 1);
            check("data", 32'(bus.m_data), 32'(sb[0]));
            check("last", 32'(bus.m_last), 32'(exp_last));
            void'(sb.pop_front());
            k_burst   = exp_last ? 0 : k_burst + 1;
            prev_last = exp_last;
         end
         n_xfer++;
      end
      @(posedge clk);
      #1;
      cyc_no++;
      s_prev = fq.size();
      if (rst) begin
         fq.delete();
         sb.delete();
         k_burst = 0;
         s_prev  = 0;
      end else if (rd_en_s) begin
         check("no_underflow", 32'(fq.size() != 0), 32'd1);
         if (fq.size() != 0) bus.rd_data = fq.pop_front();
      end
      // Flags reflect the occupancy one edge late, like the synchronised FIFO flags.
      bus.empty        = (s_prev == 0);
      bus.rd_count     = 5'(s_prev);
      bus.almost_empty = (s_prev <= int'(ALM));
   endtask

   task automatic wait_done(input int budget, input int rmod);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         bus.m_ready = (rmod == 0) ? 1'b1 : ((cyc_no % rmod) != 0);
         cyc();
         done = (sb.size() == 0) && !busy;
      end
      if (!done) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_xfer(input int budget);
      int start = n_xfer;
      for (int i = 0; i < budget && n_xfer == start; i++) cyc();
      if (n_xfer == start) check("first_xfer_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int start;
      int gap;
      int written;
      bit done;

      bus.rd_data      = '0;
      bus.rd_count     = '0;
      bus.empty        = 1'b1;
      bus.almost_empty = 1'b1;
      bus.m_ready      = 1'b0;

      rows[0] = '{n_words: 8, rmod: 0, exp_bursts: 2, exp_flush: 1'b0};
      rows[1] = '{n_words: 3, rmod: 0, exp_bursts: 1, exp_flush: 1'b1};
      rows[2] = '{n_words: 1, rmod: 0, exp_bursts: 1, exp_flush: 1'b1};
      rows[3] = '{n_words: 5, rmod: 0, exp_bursts: 2, exp_flush: 1'b0};
      rows[4] = '{n_words: 4, rmod: 3, exp_bursts: 1, exp_flush: 1'b0};
      rows[5] = '{n_words: 6, rmod: 2, exp_bursts: 2, exp_flush: 1'b0};

      rst = 1'b1;
      idle(2);
      check("rst_rd_en", 32'(bus.rd_en), 32'd0);
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_m_last", 32'(bus.m_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_m_data", 32'(bus.m_data), 32'd0);
      check("rst_burst_cnt", 32'(bcnt), 32'd0);
      rst = 1'b0;
      idle(4);

      // Preloaded bursts; a partial burst must wait out the timeout before starting.
      foreach (rows[r]) begin
         first_valid = -1;
         start       = cyc_no;
         load(rows[r].n_words);
         wait_done(400, rows[r].rmod);
         check($sformatf("row%0d_flush_delay", r), 32'((first_valid - start) >= int'(TMO)),
               32'(rows[r].exp_flush));
         exp_bcnt += rows[r].exp_bursts;
         check($sformatf("row%0d_burst_cnt", r), 32'(bcnt), 32'(exp_bcnt));
         check($sformatf("row%0d_fifo_empty", r), 32'(fq.size()), 32'd0);
         check($sformatf("row%0d_busy", r), 32'(busy), 32'd0);
         bus.m_ready = 1'b1;
         idle(4);
      end

      // Sink stalls for 5 cycles mid-burst: output held, pops stop with 2 words outstanding.
      bus.m_ready = 1'b1;
      load(8);
      wait_xfer(100);
      bus.m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (i >= 2) check("stall_no_rd_en", 32'(rd_en_s), 32'd0);
      end
      check("stall_valid", 32'(bus.m_valid), 32'd1);
      wait_done(400, 0);
      exp_bcnt += 2;
      check("stall_burst_cnt", 32'(bcnt), 32'(exp_bcnt));
      check("stall_fifo_empty", 32'(fq.size()), 32'd0);
      idle(4);

      // Reset mid-burst discards everything; a fresh 4-word load still bursts cleanly.
      bus.m_ready = 1'b1;
      load(8);
      wait_xfer(100);
      bus.m_ready = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("mid_rst_rd_en", 32'(bus.rd_en), 32'd0);
      check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("mid_rst_m_last", 32'(bus.m_last), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_burst_cnt", 32'(bcnt), 32'd0);
      exp_bcnt = 0;
      idle(3);
      load(4);
      wait_done(400, 0);
      exp_bcnt += 1;
      check("post_rst_burst_cnt", 32'(bcnt), 32'(exp_bcnt));
      check("post_rst_fifo_empty", 32'(fq.size()), 32'd0);
      idle(4);

      // 20 writes with short random gaps and a random sink; bursts must stay full.
      partial_ok = 1'b0;
      written    = 0;
      gap        = 0;
      done       = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         bus.m_ready = ($urandom_range(0, 3) != 0);
         if (written < 20) begin
            if (gap == 0) begin
               load(1);
               written++;
               gap = int'($urandom_range(0, 2));
            end else begin
               gap--;
            end
         end
         cyc();
         done = (written == 20) && (sb.size() == 0) && !busy;
      end
      if (!done) check("random_timeout", 32'd0, 32'd1);
      exp_bcnt += 5;
      check("random_burst_cnt", 32'(bcnt), 32'(exp_bcnt));
      check("random_fifo_empty", 32'(fq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
